// File: rtl/seq_mac_pkg.sv
// Shared definitions for the seq_mac shift-add multiply-accumulate unit:
// FSM state encodings and default operand/accumulator widths.
package seq_mac_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_ACC  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_mac_ctrl.sv
// Control FSM for seq_mac: sequences IDLE -> MUL (WIDTH cycles) -> ACC and
// generates the registered busy/done handshake plus datapath strobes.
module seq_mac_ctrl
  import seq_mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic ld,
  output logic mul,
  output logic acc_en
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;

  // FSM, cycle counter and handshake outputs in one registered process
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_MUL;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        ST_MUL: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= ST_ACC;
          end
        end
        ST_ACC: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Start is only honoured in IDLE, so a start while busy never reloads operands
  assign ld     = (state_r == ST_IDLE) && start;
  assign mul    = (state_r == ST_MUL);
  assign acc_en = (state_r == ST_ACC);
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: rtl/seq_mac.sv
// seq_mac: iterative unsigned WIDTH x WIDTH shift-add multiplier feeding an
// ACC_W accumulator with sticky overflow. Define SEQ_MAC_SAT_EN to saturate.
module seq_mac
  import seq_mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic             ld_s;
  logic             mul_s;
  logic             acc_en_s;
  logic [ACC_W-1:0] mcand_r;
  logic [WIDTH-1:0] mplr_r;
  logic [ACC_W-1:0] prod_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic [ACC_W:0]   sum_s;

  seq_mac_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .ld     (ld_s),
    .mul    (mul_s),
    .acc_en (acc_en_s)
  );

  // Shift-add product: one multiplier bit consumed per MUL cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r <= {ACC_W{1'b0}};
      mplr_r  <= {WIDTH{1'b0}};
      prod_r  <= {ACC_W{1'b0}};
    end else if (ld_s) begin
      mcand_r <= {{(ACC_W - WIDTH){1'b0}}, a};
      mplr_r  <= b;
      prod_r  <= {ACC_W{1'b0}};
    end else if (mul_s) begin
      if (mplr_r[0]) begin
        prod_r <= prod_r + mcand_r;
      end
      mcand_r <= mcand_r << 1;
      mplr_r  <= mplr_r >> 1;
    end
  end

  // Extra top bit carries the accumulate overflow
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, prod_r};
  end

  // Accumulator and sticky overflow; clear overrides a same-cycle accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (clear) begin
      acc_r <= {ACC_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (acc_en_s) begin
      if (sum_s[ACC_W]) begin
`ifdef SEQ_MAC_SAT_EN
        acc_r <= {ACC_W{1'b1}};
`else
        acc_r <= sum_s[ACC_W-1:0];
`endif
        ovf_r <= 1'b1;
      end else begin
        acc_r <= sum_s[ACC_W-1:0];
      end
    end
  end

  assign acc = acc_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_seq_mac.sv
// Self-checking bench for seq_mac (WIDTH=8, ACC_W=16): directed table,
// asynchronous-reset sequence, then random ops against an arithmetic model.
module tb_seq_mac;

  localparam int WIDTH = 8;
  localparam int ACC_W = 16;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  int n_checks;
  int n_fail;

  longint model_acc;
  bit     model_ovf;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    bit               clr;
    int               ign_at;
    logic [ACC_W-1:0] exp_acc;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[6];

  seq_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .clear (clear),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .acc   (acc),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference accumulate from the arithmetic rules
  task automatic model_op(input int unsigned pa, input int unsigned pb, input bit clr);
    longint sum;
    if (clr) begin
      model_acc = 0;
      model_ovf = 1'b0;
    end else begin
      sum = model_acc + longint'(pa) * longint'(pb);
      if (sum > ACC_MAX) begin
        model_ovf = 1'b1;
`ifdef SEQ_MAC_SAT_EN
        model_acc = ACC_MAX;
`else
        model_acc = sum - (ACC_MAX + 64'd1);
`endif
      end else begin
        model_acc = sum;
      end
    end
  endtask

  // Caller is at a negedge; returns at the negedge where done is high
  task automatic do_op(input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb,
                       input bit clr, input int ign_at);
    int n;
    start = 1'b1;
    a = pa;
    b = pb;
    @(negedge clk);
    start = 1'b0;
    a = '0;
    b = '0;
    chk("busy_after_start", longint'(busy), 64'd1);
    chk("done_low_in_flight", longint'(done), 64'd0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == ign_at) begin
        start = 1'b1;
        a = 8'd100;
        b = 8'd100;
      end
      if (clr && n == WIDTH + 1) clear = 1'b1;
      if (n != WIDTH + 1) begin
        if (done !== 1'b0) chk("done_extra_pulse", longint'(done), 64'd0);
      end
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
    end
    chk("busy_cycles", longint'(n), longint'(WIDTH + 1));
    chk("done_pulse", longint'(done), 64'd1);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_acc = 0;
    model_ovf = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{8'd13,  8'd11,  1'b0, 0, 16'd143,   1'b0};
    vecs[1] = '{8'd255, 8'd255, 1'b0, 0, 16'hFE90,  1'b0};
`ifdef SEQ_MAC_SAT_EN
    vecs[2] = '{8'd2,   8'd200, 1'b0, 0, 16'hFFFF,  1'b1};
    vecs[3] = '{8'd3,   8'd4,   1'b0, 3, 16'hFFFF,  1'b1};
`else
    vecs[2] = '{8'd2,   8'd200, 1'b0, 0, 16'h0020,  1'b1};
    vecs[3] = '{8'd3,   8'd4,   1'b0, 3, 16'h002C,  1'b1};
`endif
    vecs[4] = '{8'd5,   8'd5,   1'b1, 0, 16'd0,     1'b0};
    vecs[5] = '{8'd0,   8'd77,  1'b0, 0, 16'd0,     1'b0};

    repeat (3) @(negedge clk);
    chk("reset_busy", longint'(busy), 64'd0);
    chk("reset_done", longint'(done), 64'd0);
    chk("reset_acc",  longint'(acc),  64'd0);
    chk("reset_ovf",  longint'(ovf),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].clr, vecs[i].ign_at);
      chk($sformatf("vec%0d_acc", i), longint'(acc), longint'(vecs[i].exp_acc));
      chk($sformatf("vec%0d_ovf", i), longint'(ovf), longint'(vecs[i].exp_ovf));
    end
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 64'd0);

    // Accumulate something, then reset in the middle of the next MUL
    do_op(8'd9, 8'd9, 1'b0, 0);
    start = 1'b1;
    a = 8'd50;
    b = 8'd50;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", longint'(busy), 64'd0);
    chk("async_rst_done", longint'(done), 64'd0);
    chk("async_rst_acc",  longint'(acc),  64'd0);
    chk("async_rst_ovf",  longint'(ovf),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'd6, 8'd7, 1'b0, 0);
    chk("post_rst_acc", longint'(acc), 64'd42);
    chk("post_rst_ovf", longint'(ovf), 64'd0);
    model_acc = 42;
    model_ovf = 1'b0;

    // Random back-to-back ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      bit rc;
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      rc = ($urandom_range(0, 9) == 0);
      do_op(ra, rb, rc, 0);
      model_op(ra, rb, rc);
      chk($sformatf("rand%0d_acc", i), longint'(acc), model_acc);
      chk($sformatf("rand%0d_ovf", i), longint'(ovf), longint'(model_ovf));
    end

    // Clear together with start in IDLE: both take effect
    clear = 1'b1;
    do_op(8'd10, 8'd10, 1'b0, 0);
    chk("clear_start_acc", longint'(acc), 64'd100);
    chk("clear_start_ovf", longint'(ovf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
